// File: rtl/mux_arb_if.sv
// mux_arb_if: stream bus between N producers, the mux_arb block and one consumer.
// master = producer/consumer side (testbench), slave = mux_arb side.
interface mux_arb_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
);
  localparam int unsigned SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_last;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_sel;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_sel, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_sel, out_last, out_valid
  );
endinterface

// File: rtl/mux_arb.sv
// mux_arb: N-channel registered stream mux with round-robin arbitration.
// Optional packet lock (grant held until in_last) when MUX_ARB_PKT_LOCK_EN is defined.
module mux_arb #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic       clk,
  input  logic       rst,
  mux_arb_if.slave   bus
);
  localparam int unsigned SELW = $clog2(N);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  grant;
  logic             grant_vld;
  logic [SELW-1:0]  cand;
  logic             load;
  logic             xfer;
  logic [WIDTH-1:0] grant_data;
  logic [SELW-1:0]  ptr_nxt;

`ifdef MUX_ARB_PKT_LOCK_EN
  logic             lock;
  logic [SELW-1:0]  lock_ch;
`endif

  assign load = !bus.out_valid || bus.out_ready;

  // Round-robin search from ptr; a held packet lock overrides the search.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = 0; k < int'(N); k++) begin
      cand = SELW'((int'(ptr) + k) % int'(N));
      if (!grant_vld && bus.in_valid[cand]) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
`ifdef MUX_ARB_PKT_LOCK_EN
    if (lock) begin
      grant     = lock_ch;
      grant_vld = bus.in_valid[lock_ch];
    end
`endif
  end

  assign xfer       = load && grant_vld;
  assign grant_data = bus.in_data[int'(grant)*int'(WIDTH) +: WIDTH];
  assign ptr_nxt    = (int'(grant) == int'(N) - 1) ? '0 : grant + SELW'(1);

  // One-hot accept toward the granted channel, forced low during reset.
  always_comb begin
    bus.in_ready = '0;
    if (!rst && xfer) bus.in_ready[grant] = 1'b1;
  end

  // Output register stage and arbitration pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
      bus.out_last  <= 1'b0;
      ptr           <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= grant_data;
      bus.out_sel   <= grant;
      bus.out_last  <= bus.in_last[grant];
      ptr           <= ptr_nxt;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MUX_ARB_PKT_LOCK_EN
  // Packet lock: set by a non-last beat, cleared by the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock    <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      lock    <= !bus.in_last[grant];
      lock_ch <= grant;
    end
  end
`endif
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed checks of mux_arb with N=4 and N=3 instances.
module tb_mux_arb;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_arb_if #(.WIDTH(8), .N(4)) a ();
  mux_arb_if #(.WIDTH(8), .N(3)) b ();

  mux_arb #(.WIDTH(8), .N(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
  mux_arb #(.WIDTH(8), .N(3)) dut_b (.clk(clk), .rst(rst), .bus(b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_r4;
    logic [2:0] exp_r3;

    rst         = 1'b1;
    a.in_data   = '0;
    a.in_valid  = 4'b1111;
    a.in_last   = '0;
    a.out_ready = 1'b1;
    b.in_data   = '0;
    b.in_valid  = '0;
    b.in_last   = '0;
    b.out_ready = 1'b1;
    #2;
    check("rst_in_ready", 32'(a.in_ready), 32'h0);
    tick();
    check("rst_in_ready2", 32'(a.in_ready), 32'h0);
    a.in_valid = '0;
    tick();
    rst = 1'b0;

    // Idle after reset release
    for (int i = 0; i < 5; i++) begin
      #1;
      check("idle_valid", 32'(a.out_valid), 32'h0);
      check("idle_data", 32'(a.out_data), 32'h0);
      check("idle_sel", 32'(a.out_sel), 32'h0);
      check("idle_last", 32'(a.out_last), 32'h0);
      check("idle_ready", 32'(a.in_ready), 32'h0);
      tick();
    end
    check("idle_b_valid", 32'(b.out_valid), 32'h0);

    // All channels valid: round robin on both instances
    a.in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    b.in_data  = {8'h22, 8'h21, 8'h20};
    a.in_valid = 4'b1111;
    b.in_valid = 3'b111;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_r4 = 4'b0001 << (c % 4);
      exp_r3 = 3'b001 << (c % 3);
      check("rr4_ready", 32'(a.in_ready), 32'(exp_r4));
      check("rr3_ready", 32'(b.in_ready), 32'(exp_r3));
      tick();
      check("rr4_sel", 32'(a.out_sel), 32'(c % 4));
      check("rr4_data", 32'(a.out_data), 32'(8'h10 + c % 4));
      check("rr4_valid", 32'(a.out_valid), 32'h1);
      check("rr3_sel", 32'(b.out_sel), 32'(c % 3));
      check("rr3_data", 32'(b.out_data), 32'(8'h20 + c % 3));
    end
    a.in_valid = '0;
    b.in_valid = '0;
    tick();
    check("drain_valid", 32'(a.out_valid), 32'h0);
    check("drain_hold", 32'(a.out_data), 32'h13);

    // Single channel 2 with last
    a.in_data  = {8'h00, 8'hA5, 8'h00, 8'h00};
    a.in_valid = 4'b0100;
    a.in_last  = 4'b0100;
    #1;
    check("one_ready", 32'(a.in_ready), 32'h4);
    tick();
    check("one_valid", 32'(a.out_valid), 32'h1);
    check("one_data", 32'(a.out_data), 32'hA5);
    check("one_sel", 32'(a.out_sel), 32'h2);
    check("one_last", 32'(a.out_last), 32'h1);
    a.in_valid = '0;
    a.in_last  = '0;
    tick();
    check("one_drain", 32'(a.out_valid), 32'h0);
    check("one_hold", 32'(a.out_data), 32'hA5);

    // Backpressure: ptr=3, channels 0 and 1 valid
    a.in_data  = {8'h00, 8'h00, 8'h31, 8'h30};
    a.in_valid = 4'b0011;
    #1;
    check("bp_ready0", 32'(a.in_ready), 32'h1);
    tick();
    check("bp_data0", 32'(a.out_data), 32'h30);
    a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall_ready", 32'(a.in_ready), 32'h0);
      tick();
      check("bp_stall_data", 32'(a.out_data), 32'h30);
      check("bp_stall_valid", 32'(a.out_valid), 32'h1);
    end
    a.out_ready = 1'b1;
    #1;
    check("bp_ready1", 32'(a.in_ready), 32'h2);
    tick();
    check("bp_data1", 32'(a.out_data), 32'h31);
    check("bp_sel1", 32'(a.out_sel), 32'h1);
    check("bp_nobubble", 32'(a.out_valid), 32'h1);
    a.in_valid = '0;
    tick();
    check("bp_drain", 32'(a.out_valid), 32'h0);

    // Reset with a beat held: ptr=2, grant channel 0 -> ptr becomes 1
    a.in_valid = 4'b0001;
    tick();
    check("rstmid_held", 32'(a.out_valid), 32'h1);
    a.out_ready = 1'b0;
    a.in_valid  = '0;
    rst = 1'b1;
    #1;
    check("rstmid_valid", 32'(a.out_valid), 32'h0);
    check("rstmid_data", 32'(a.out_data), 32'h0);
    tick();
    rst = 1'b0;
    a.out_ready = 1'b1;
    a.in_valid  = 4'b1111;
    #1;
    check("rstmid_ptr0", 32'(a.in_ready), 32'h1);
    a.in_valid = '0;
    tick();

`ifdef MUX_ARB_PKT_LOCK_EN
    // Packet lock: channel 1 sends 3 beats while channel 0 stays valid
    tick();
    a.in_data  = {8'h00, 8'h00, 8'h41, 8'h40};
    a.in_last  = 4'b0001;
    a.in_valid = 4'b0001;
    tick();
    check("lk_pre_sel", 32'(a.out_sel), 32'h0);
    a.in_valid = 4'b0011;
    #1;
    check("lk_r1", 32'(a.in_ready), 32'h2);
    tick();
    check("lk_sel1", 32'(a.out_sel), 32'h1);
    check("lk_data1", 32'(a.out_data), 32'h41);
    a.in_valid = 4'b0001;
    #1;
    check("lk_idle_ready", 32'(a.in_ready), 32'h0);
    tick();
    check("lk_idle_valid", 32'(a.out_valid), 32'h0);
    a.in_valid = 4'b0011;
    a.in_data  = {8'h00, 8'h00, 8'h42, 8'h40};
    #1;
    check("lk_r2", 32'(a.in_ready), 32'h2);
    tick();
    check("lk_sel2", 32'(a.out_sel), 32'h1);
    a.in_data = {8'h00, 8'h00, 8'h43, 8'h40};
    a.in_last = 4'b0011;
    #1;
    check("lk_r3", 32'(a.in_ready), 32'h2);
    tick();
    check("lk_sel3", 32'(a.out_sel), 32'h1);
    check("lk_last3", 32'(a.out_last), 32'h1);
    #1;
    check("lk_r4", 32'(a.in_ready), 32'h1);
    tick();
    check("lk_sel4", 32'(a.out_sel), 32'h0);
    check("lk_data4", 32'(a.out_data), 32'h40);
    a.in_valid = '0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
